// File: rtl/snax_fpga_spm_ctrl.sv
// rtl/snax_fpga_spm_ctrl.sv - multi-bank scratchpad controller
// Word-interleaved banks, fixed read latency and a credit-limited in-order response queue.
module snax_fpga_spm_ctrl #(
   parameter int unsigned          AddrWidth   = 48,
   parameter int unsigned          DataWidth   = 64,
   parameter int unsigned          NumWords    = 65536,
   parameter int unsigned          NumBanks    = 1,
   parameter int unsigned          ReadLatency = 2,
   parameter int unsigned          RspDepth    = 4,
   parameter logic [AddrWidth-1:0] BaseAddr    = 48'h80000000,
   localparam int unsigned         StrbWidth   = DataWidth / 8,
   localparam int unsigned         CntWidth    = $clog2(RspDepth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic                 we_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [StrbWidth-1:0] strb_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 busy_o,
   output logic [CntWidth-1:0]  outstanding_o
);

   localparam int unsigned OffShift  = $clog2(StrbWidth);
   localparam int unsigned BankShift = $clog2(NumBanks);
   localparam int unsigned BankWidth = (NumBanks > 1) ? BankShift : 1;
   localparam int unsigned Rows      = NumWords / NumBanks;
   localparam int unsigned RowWidth  = (Rows > 1) ? $clog2(Rows) : 1;
   localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int unsigned PipeDepth = (ReadLatency > 1) ? ReadLatency - 1 : 1;

   logic [AddrWidth-1:0] offset;
   logic [AddrWidth-1:0] word;
   logic [BankWidth-1:0] bank;
   logic [RowWidth-1:0]  row;
   logic                 out_of_range;
   logic                 accept;
   logic                 pop;
   logic                 wr_en;
   logic                 rd_en;

   assign offset       = addr_i - BaseAddr;
   assign word         = offset >> OffShift;
   assign out_of_range = (addr_i < BaseAddr) || (word >= AddrWidth'(NumWords));
   assign bank         = BankWidth'(word & AddrWidth'(NumBanks - 1));
   assign row          = RowWidth'(word >> BankShift);

   assign accept = req_i & gnt_o;
   assign pop    = rsp_valid_o & rsp_ready_i;
   assign wr_en  = accept & we_i & ~out_of_range;
   assign rd_en  = accept & ~we_i & ~out_of_range;

   // Credits: granted from registered state only, so no path from req/ready to gnt.
   logic [CntWidth-1:0] out_q;

   assign gnt_o         = (out_q < CntWidth'(RspDepth));
   assign busy_o        = (out_q != '0);
   assign outstanding_o = out_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q <= '0;
      end else if (accept && !pop) begin
         out_q <= out_q + CntWidth'(1);
      end else if (!accept && pop) begin
         out_q <= out_q - CntWidth'(1);
      end
   end

   logic [DataWidth-1:0] mem [NumBanks][Rows];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (strb_i[b]) begin
               mem[bank][row][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   logic                 push_valid;
   logic                 push_err;
   logic                 push_we;
   logic [DataWidth-1:0] push_rdata;
   logic [DataWidth-1:0] push_data;

   if (ReadLatency == 1) begin : g_lat1
      assign push_valid = accept;
      assign push_err   = out_of_range;
      assign push_we    = we_i;
      assign push_rdata = mem[bank][row];
   end else begin : g_pipe
      logic [PipeDepth-1:0] vld_q;
      logic [PipeDepth-1:0] err_q;
      logic [PipeDepth-1:0] we_q;
      logic [DataWidth-1:0] data_q [PipeDepth];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            we_q  <= '0;
         end else begin
            vld_q[0] <= accept;
            err_q[0] <= out_of_range;
            we_q[0]  <= we_i;
            for (int k = 1; k < PipeDepth; k++) begin
               vld_q[k] <= vld_q[k-1];
               err_q[k] <= err_q[k-1];
               we_q[k]  <= we_q[k-1];
            end
         end
      end

      // Registered bank read (BRAM output register) followed by plain delay stages.
      always_ff @(posedge clk_i) begin
         if (rd_en) begin
            data_q[0] <= mem[bank][row];
         end
         for (int k = 1; k < PipeDepth; k++) begin
            data_q[k] <= data_q[k-1];
         end
      end

      assign push_valid = vld_q[PipeDepth-1];
      assign push_err   = err_q[PipeDepth-1];
      assign push_we    = we_q[PipeDepth-1];
      assign push_rdata = data_q[PipeDepth-1];
   end

   assign push_data = (push_we || push_err) ? '0 : push_rdata;

   // Fall-through response queue; credits guarantee a free slot for every push.
   logic [DataWidth-1:0] q_data [RspDepth];
   logic [RspDepth-1:0]  q_err;
   logic [PtrWidth-1:0]  wr_ptr;
   logic [PtrWidth-1:0]  rd_ptr;
   logic [CntWidth-1:0]  q_cnt;

   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (push_valid) begin
         q_data[wr_ptr] <= push_data;
         q_err[wr_ptr]  <= push_err;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_cnt  <= '0;
      end else begin
         if (push_valid) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push_valid && !pop) begin
            q_cnt <= q_cnt + CntWidth'(1);
         end else if (!push_valid && pop) begin
            q_cnt <= q_cnt - CntWidth'(1);
         end
      end
   end

   assign rsp_valid_o = (q_cnt != '0);
   assign rsp_rdata_o = rsp_valid_o ? q_data[rd_ptr] : '0;
   assign rsp_err_o   = rsp_valid_o & q_err[rd_ptr];

endmodule

// File: tb/tb_snax_fpga_spm_ctrl.sv
// tb/tb_snax_fpga_spm_ctrl.sv - directed self-checking bench for snax_fpga_spm_ctrl
module tb_snax_fpga_spm_ctrl;

   localparam logic [47:0] Base = 48'h80000000;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        gnt;
   logic [47:0] addr;
   logic        we;
   logic [63:0] wdata;
   logic [7:0]  strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [2:0]  outstanding;

   snax_fpga_spm_ctrl #(
      .AddrWidth  (48),
      .DataWidth  (64),
      .NumWords   (64),
      .NumBanks   (4),
      .ReadLatency(2),
      .RspDepth   (4),
      .BaseAddr   (Base)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .gnt_o        (gnt),
      .addr_i       (addr),
      .we_i         (we),
      .wdata_i      (wdata),
      .strb_i       (strb),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_err_o    (rsp_err),
      .busy_o       (busy),
      .outstanding_o(outstanding)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One isolated transaction with ready held high; checks grant and exact latency.
   task automatic run_txn(input logic w, input logic [47:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [63:0] ed, input logic ee,
                          input string nm);
      req = 1'b1; we = w; addr = a; wdata = d; strb = s; rsp_ready = 1'b1;
      @(negedge clk);
      chk({nm, " gnt"}, 64'(gnt), 64'd1);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk({nm, " early"}, 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk({nm, " valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, " rdata"}, rsp_rdata, ed);
      chk({nm, " err"}, 64'(rsp_err), 64'(ee));
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        we;
      logic [47:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [63:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t vecs[14];

   logic [63:0] exp_q[$];
   int          rsp_n;
   int          acc;
   int          stale;
   bit          drained;

   initial begin
      vecs[0]  = '{1'b1, Base + 48'h8,   64'h1122334455667788, 8'hFF, 64'h0, 1'b0, "wr_full"};
      vecs[1]  = '{1'b0, Base + 48'h8,   64'h0, 8'h00, 64'h1122334455667788, 1'b0, "rd_full"};
      vecs[2]  = '{1'b1, Base + 48'h8,   64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0, "wr_strb"};
      vecs[3]  = '{1'b0, Base + 48'h8,   64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0, "rd_strb"};
      vecs[4]  = '{1'b1, Base + 48'h1F8, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0, "wr_last"};
      vecs[5]  = '{1'b1, Base,           64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, "wr_w0"};
      vecs[6]  = '{1'b0, 48'h7FFFFFF8,   64'h0, 8'h00, 64'h0, 1'b1, "rd_below"};
      vecs[7]  = '{1'b0, Base + 48'h200, 64'h0, 8'h00, 64'h0, 1'b1, "rd_above"};
      vecs[8]  = '{1'b1, Base + 48'h200, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1, "wr_above"};
      vecs[9]  = '{1'b1, 48'h7FFFFFF8,   64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1, "wr_below"};
      vecs[10] = '{1'b0, Base,           64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0, "rd_w0"};
      vecs[11] = '{1'b0, Base + 48'h1F8, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0, "rd_last"};
      vecs[12] = '{1'b1, Base + 48'hF,   64'h5500000000000066, 8'h81, 64'h0, 1'b0, "wr_offs"};
      vecs[13] = '{1'b0, Base + 48'hD,   64'h0, 8'h00, 64'h55223344AAAAAA66, 1'b0, "rd_offs"};

      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; strb = '0; rsp_ready = 1'b0;
      #12;
      chk("rst gnt", 64'(gnt), 64'd1);
      chk("rst valid", 64'(rsp_valid), 64'd0);
      chk("rst rdata", rsp_rdata, 64'd0);
      chk("rst err", 64'(rsp_err), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst outstanding", 64'(outstanding), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
      end

      // Backpressure: only RspDepth requests may be accepted while ready is low.
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         req = 1'b1; we = 1'b0; addr = Base;
         @(negedge clk);
         if (gnt) acc++;
         @(posedge clk); #1;
      end
      req = 1'b0;
      chk("bp accepted", 64'(acc), 64'd4);
      @(negedge clk);
      chk("bp gnt low", 64'(gnt), 64'd0);
      chk("bp outstanding", 64'(outstanding), 64'd4);
      chk("bp busy", 64'(busy), 64'd1);
      chk("bp head data", rsp_rdata, 64'h0123456789ABCDEF);
      @(negedge clk);
      chk("bp head stable", rsp_rdata, 64'h0123456789ABCDEF);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp pop valid", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp gnt back", 64'(gnt), 64'd1);
      chk("bp outstanding 3", 64'(outstanding), 64'd3);
      rsp_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         @(negedge clk);
         if (outstanding == 3'd0) drained = 1'b1;
      end
      chk("bp drained", 64'(drained), 64'd1);
      chk("bp busy low", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Back-to-back streams across all four banks: writes, then reads.
      for (int pass = 0; pass < 2; pass++) begin
         exp_q.delete();
         for (int i = 0; i < 8; i++) begin
            exp_q.push_back((pass == 0) ? 64'h0 : (64'hA5A5000000000000 | 64'(i)));
         end
         rsp_n = 0;
         fork
            begin
               for (int i = 0; i < 8; i++) begin
                  req = 1'b1; we = (pass == 0); addr = Base + 48'(8 * i);
                  wdata = 64'hA5A5000000000000 | 64'(i); strb = 8'hFF;
                  @(negedge clk);
                  chk($sformatf("stream%0d gnt %0d", pass, i), 64'(gnt), 64'd1);
                  @(posedge clk); #1;
               end
               req = 1'b0;
            end
            begin
               for (int c = 0; c < 16; c++) begin
                  @(negedge clk);
                  if (rsp_valid) begin
                     chk($sformatf("stream%0d slot %0d", pass, rsp_n), 64'(c), 64'(2 + rsp_n));
                     if (rsp_n < 8) begin
                        chk($sformatf("stream%0d data %0d", pass, rsp_n), rsp_rdata, exp_q[rsp_n]);
                     end
                     rsp_n++;
                  end
               end
            end
         join
         chk($sformatf("stream%0d count", pass), 64'(rsp_n), 64'd8);
         @(posedge clk); #1;
      end

      // Asynchronous reset with three requests in flight.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req = 1'b1; we = 1'b0; addr = Base;
         @(posedge clk); #1;
      end
      req = 1'b0;
      @(negedge clk);
      chk("pre-rst outstanding", 64'(outstanding), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid-rst valid", 64'(rsp_valid), 64'd0);
      chk("mid-rst outstanding", 64'(outstanding), 64'd0);
      chk("mid-rst busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) chk("post-rst gnt", 64'(gnt), 64'd1);
         if (rsp_valid) stale++;
      end
      chk("post-rst stale", 64'(stale), 64'd0);
      @(posedge clk); #1;
      run_txn(1'b0, Base, 64'h0, 8'h00, 64'hA5A5000000000000, 1'b0, "post-rst rd_w0");
      run_txn(1'b0, Base + 48'h1F8, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0, "post-rst rd_last");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
